// File: rtl/tron_pkg.sv
// Shared board geometry, colour codes and RAM address packing for the tron
// datapath: writer, move logic and board scanner all import this.
package tron_pkg;

    localparam int BOARD_COLS = 160;
    localparam int BOARD_ROWS = 120;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int ADDR_W     = X_W + Y_W;

    typedef enum logic [2:0] {
        COL_BLANK = 3'b000,
        COL_P1    = 3'b001,
        COL_P2    = 3'b010,
        COL_P3    = 3'b100,
        COL_P4    = 3'b110,
        COL_CRASH = 3'b111
    } colour_e;

    typedef struct packed {
        logic           vld;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DRAIN
    } scan_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/coord_pipe.sv
// Delay line that carries issued cell coordinates alongside the RAM read so
// they arrive together with the matching read data.
module coord_pipe
    import tron_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk_i,
    input  logic   clr_i,
    input  coord_t push_i,
    output coord_t pop_o,
    output logic   busy_o
);

    coord_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign pop_o = stage_q[DEPTH-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].vld;
    end

endmodule

// File: rtl/board_scanner.sv
// Raster sweep of the board RAM into the VGA plot stream, one cell per cycle,
// yielding the RAM port to the trail writer while hold is high.
module board_scanner
    import tron_pkg::*;
#(
    parameter int COLS       = BOARD_COLS,
    parameter int ROWS       = BOARD_ROWS,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [2:0]        rd_q,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              done,
    output logic              missed
);

    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    scan_state_e    state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    coord_t         iss_q, iss_d;
    logic           done_q, done_d;
    logic           missed_q, missed_d;
    logic [X_W-1:0] vga_x_q;
    logic [Y_W-1:0] vga_y_q;
    logic [2:0]     vga_colour_q;
    logic           vga_plot_q;

    logic           issue;
    logic           last_cell;
    logic           pipe_busy;
    coord_t         pipe_out;

    assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= SCAN_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            iss_q    <= '0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            iss_q    <= iss_d;
            done_q   <= done_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        done_d   = 1'b0;
        missed_d = missed_q;
        case (state_q)
            SCAN_IDLE: begin
                if (start) begin
                    state_d = SCAN_RUN;
                    if (!hold) begin
                        issue = 1'b1;
                        if (last_cell) state_d = SCAN_DRAIN;
                    end
                end
            end
            SCAN_RUN: begin
                if (start) missed_d = 1'b1;
                if (!hold) begin
                    issue = 1'b1;
                    if (last_cell) state_d = SCAN_DRAIN;
                end
            end
            SCAN_DRAIN: begin
                if (start) missed_d = 1'b1;
                // Empty means the last read has been plotted already.
                if (!iss_q.vld && !pipe_busy) begin
                    state_d = SCAN_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    // Counters wrap back to (0,0) after the last cell, ready for the next frame.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        iss_d = iss_q;
        iss_d.vld = issue;
        if (issue) begin
            iss_d.x = x_q;
            iss_d.y = y_q;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    assign rd_address = pack_addr(iss_q.x, iss_q.y);

    coord_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_coord_pipe (
        .clk_i  (CLOCK_50),
        .clr_i  (reset),
        .push_i (iss_q),
        .pop_o  (pipe_out),
        .busy_o (pipe_busy)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else if (pipe_out.vld) begin
            vga_x_q      <= pipe_out.x;
            vga_y_q      <= pipe_out.y;
            vga_colour_q <= rd_q;
            vga_plot_q   <= 1'b1;
        end else begin
            vga_plot_q   <= 1'b0;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = (state_q != SCAN_IDLE);
    assign done       = done_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench: two scanners (read latency 1 and 2) sweep a modelled board RAM.
module tb_board_scanner;
    import tron_pkg::*;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0, hold = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] addr [2];
    logic [2:0]  rdq  [2];
    logic [7:0]  vx   [2];
    logic [6:0]  vy   [2];
    logic [2:0]  vc   [2];
    logic        vp   [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic        mis  [2];

    board_scanner #(.COLS(160), .ROWS(120), .RD_LATENCY(1)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .hold(hold),
        .rd_address(addr[0]), .rd_q(rdq[0]), .vga_x(vx[0]), .vga_y(vy[0]),
        .vga_colour(vc[0]), .vga_plot(vp[0]), .busy(bsy[0]), .done(dn[0]), .missed(mis[0]));

    board_scanner #(.COLS(160), .ROWS(120), .RD_LATENCY(2)) dut2 (
        .CLOCK_50(clk), .reset(reset), .start(start2), .hold(hold),
        .rd_address(addr[1]), .rd_q(rdq[1]), .vga_x(vx[1]), .vga_y(vy[1]),
        .vga_colour(vc[1]), .vga_plot(vp[1]), .busy(bsy[1]), .done(dn[1]), .missed(mis[1]));

    // Board RAM with registered read, extra stage for the latency-2 instance
    logic [2:0] mem [32768];
    logic [2:0] q1a, q2a, q2b;
    always @(posedge clk) begin
        q1a <= mem[addr[0]];
        q2a <= mem[addr[1]];
        q2b <= q2a;
    end
    assign rdq[0] = q1a;
    assign rdq[1] = q2b;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Plot scoreboard: strict raster order, colour taken from the RAM model
    int         nplot [2], ord_err [2], first_e [2], last_e [2];
    logic [7:0] ex [2];
    logic [6:0] ey [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                nplot[d] = 0; ord_err[d] = 0; ex[d] = '0; ey[d] = '0;
                first_e[d] = -1; last_e[d] = -1;
            end else if (vp[d]) begin
                if (nplot[d] == 0) first_e[d] = edge_n;
                last_e[d] = edge_n;
                if (vx[d] !== ex[d] || vy[d] !== ey[d] || vc[d] !== mem[{ex[d], ey[d]}])
                    ord_err[d]++;
                nplot[d]++;
                if (ex[d] == 8'd159) begin
                    ex[d] = '0;
                    ey[d] = (ey[d] == 7'd119) ? 7'd0 : 7'(ey[d] + 7'd1);
                end else begin
                    ex[d] = 8'(ex[d] + 8'd1);
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int t = 0;
        while (!dn[0] && t < 25000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, dn[0], 1);
    endtask

    initial begin
        int e0, eb;
        for (int i = 0; i < 32768; i++) mem[i] = COL_BLANK;
        mem[15'h0000] = COL_P1;
        mem[15'h4FF7] = COL_P4;

        repeat (3) @(negedge clk);
        chk("rst_addr", addr[0], 0);
        chk("rst_plot", vp[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_missed", mis[0], 0);
        chk("rst_vga", {vx[0], vy[0], vc[0]}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Frame 1: plain sweep on both latencies
        start = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0; e0 = edge_n;
        chk("f1_busy", bsy[0], 1);
        wait_done("f1_done_seen");
        chk("f1_done_edge", edge_n, e0 + 19202);
        chk("f1_busy_fall", bsy[0], 0);
        chk("f1_first_plot", first_e[0], e0 + 2);
        chk("f1_last_plot", last_e[0], e0 + 19201);
        chk("f1_nplot", nplot[0], 19200);
        chk("f1_order", ord_err[0], 0);
        chk("f1_last_xyc", {vx[0], vy[0], vc[0]}, {8'd159, 7'd119, 3'b110});
        chk("f1_last_addr", addr[0], 15'h4FF7);
        chk("f1_missed", mis[0], 0);

        // Frame 2: start in the done cycle, together with hold
        start = 1'b1; hold = 1'b1;
        @(negedge clk);
        start = 1'b0; eb = edge_n;
        chk("f2_accept", bsy[0], 1);
        chk("f1_done_pulse", dn[0], 0);
        chk("f2_no_miss", mis[0], 0);
        chk("l2_done", dn[1], 1);
        @(negedge clk);
        @(negedge clk);
        hold = 1'b0;
        chk("l2_first_plot", first_e[1], e0 + 3);
        chk("l2_last_plot", last_e[1], e0 + 19202);
        chk("l2_nplot", nplot[1], 19200);
        chk("l2_order", ord_err[1], 0);
        @(negedge clk);
        chk("f2_first_addr", addr[0], 0);
        chk("f2_plot_e3", vp[0], 0);
        @(negedge clk);
        chk("f2_plot_e4", vp[0], 0);
        @(negedge clk);
        chk("f2_first_xyc", {vp[0], vx[0], vy[0], vc[0]}, {1'b1, 8'd0, 7'd0, 3'b001});
        mem[15'h4FF7] = COL_CRASH;

        while (edge_n < eb + 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("f2_missed", mis[0], 1);
        chk("f2_busy_kept", bsy[0], 1);

        while (edge_n < eb + 5000) @(negedge clk);
        hold = 1'b1;
        chk("hold_addr_in", addr[0], 15'h129F);
        repeat (10) @(negedge clk);
        chk("hold_addr_out", addr[0], 15'h129F);
        hold = 1'b0;
        wait_done("f2_done_seen");
        chk("f2_done_edge", edge_n, eb + 19215);
        chk("f2_last_plot", last_e[0], eb + 19214);
        chk("f2_nplot", nplot[0], 38400);
        chk("f2_order", ord_err[0], 0);
        chk("f2_crash_xyc", {vx[0], vy[0], vc[0]}, {8'd159, 7'd119, 3'b111});
        chk("f2_missed_sticky", mis[0], 1);

        // Reset in the middle of a sweep, then restart
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; e0 = edge_n;
        while (edge_n < e0 + 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("f3_missed", mis[0], 1);
        begin
            int t = 0;
            while (nplot[0] < 5000 && t < 6000) begin
                @(negedge clk);
                t++;
            end
            chk("f3_reach_5000", nplot[0] >= 5000, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_plot", vp[0], 0);
        chk("mrst_busy", bsy[0], 0);
        chk("mrst_addr", addr[0], 0);
        chk("mrst_missed", mis[0], 0);
        chk("mrst_done", dn[0], 0);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("f4_plot_e1", vp[0], 0);
        @(negedge clk);
        chk("f4_first_xyc", {vp[0], vx[0], vy[0], vc[0]}, {1'b1, 8'd0, 7'd0, 3'b001});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/board_scanner.md
# board_scanner

- Read-side companion to the trail-writing RAM update logic.
- Sweeps the 160x120 game board held in the shared 32768x3 RAM, one cell per cycle in raster order.
- Each cell's 3-bit colour is forwarded to the VGA adapter as an (x, y, colour, plot) stream, one frame per `start` pulse (normally driven from the game tick).
- Yields the single RAM port to the writer whenever `hold` is asserted, without losing or duplicating cells.

## Interface

Parameters:
- COLS, 160, board width in cells (1..256)
- ROWS, 120, board height in cells (1..128)
- RD_LATENCY, 1, cycles from `rd_address` register update to matching `rd_q` (1 or 2)

Ports (one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to sweep one frame
- hold  in  1  writer owns RAM port; issue no new reads
- rd_address  out  15  {x[7:0], y[6:0]} read address to RAM
- rd_q  in  3  RAM read data, RD_LATENCY cycles after address
- vga_x  out  8  plotted cell X
- vga_y  out  7  plotted cell Y
- vga_colour  out  3  colour of plotted cell
- vga_plot  out  1  vga_x/y/colour valid this cycle
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, frame complete
- missed  out  1  sticky: `start` arrived while busy

## Operation

- FSM states and transitions:
  - IDLE -> SCAN on `start`.
  - SCAN -> DRAIN after the last address (COLS-1, ROWS-1) is issued.
  - DRAIN -> IDLE when the pipeline is empty.
- Issue counters:
  - x counts 0..COLS-1, then wraps to 0 and increments y.
  - y counts 0..ROWS-1.
  - Counters never exceed their 8/7-bit widths.
- Each non-held SCAN cycle issues exactly one address and pushes (valid, x, y) into a RD_LATENCY-deep coordinate pipe.
- When the pipe output is valid: register vga_x/vga_y from the pipe, vga_colour <= rd_q, vga_plot <= 1. Otherwise vga_plot <= 0; x/y/colour hold.
- Every cell is plotted, blanks (000) included, so the frame is fully repainted.
- Colour codes pass through unmodified: 000 blank, 001 P1, 010 P2, 100 P3, 110 P4, 111 collision.
- `hold`=1 in SCAN: counters and `rd_address` frozen, no push. In-flight reads still complete and plot.
- `hold` in IDLE or DRAIN: no effect.
- `start` while busy: ignored, `missed` <= 1. `missed` clears only on reset.
- `start` and `hold` together in IDLE: enter SCAN; the first issue waits until `hold` drops.
- Reset at any time, including mid-sweep:
  - Next edge: IDLE, counters 0, pipe cleared.
  - Outputs: rd_address 0, vga_x/y/colour 0, vga_plot 0, busy 0, done 0, missed 0.

## Timing

- `start` sampled at edge E0: state becomes SCAN and first address {0,0} is registered at E0.
- rd_q valid after edge E0+RD_LATENCY; first vga_plot registered at E0+RD_LATENCY+1.
- Without hold:
  - Addresses issue at E0..E0+COLS*ROWS-1.
  - Last plot is registered at E0+COLS*ROWS+RD_LATENCY.
  - done is registered one edge later.
- Each held cycle delays all subsequent plots and done by exactly one cycle.
- busy = (state != IDLE). busy is registered at E0 and falls on the same edge done rises.
- done is high for exactly one cycle.
- Back-to-back frames: a `start` in the done cycle is accepted.
- Throughput: one plot per non-held cycle; plot order is strictly raster (x inner, y outer).

## Structure

- Shared package `tron_pkg`:
  - Board dimensions 160/120 and coordinate widths 8/7.
  - Colour code constants.
  - Address pack function {x, y}.
  - This package is also used by the RAM update and move logic.
- One sub-module, `coord_pipe`: a parameterised RD_LATENCY-deep shift register of {valid, x, y} with synchronous clear.

## Test plan

- RAM preloaded with (0,0)=001, (159,119)=110, rest 000; start at E0 with RD_LATENCY=1.
  - First plot at E0+2: x=0, y=0, colour 001.
  - 19200 plots total; last is x=159, y=119, colour 110 at E0+19201.
  - done at E0+19202; busy falls at the same edge.
- hold high for 10 cycles at cell 5000 -> 19200 plots, no skips or duplicates, done at E0+19212.
- start pulsed at E0+100 during a sweep -> ignored, missed=1, plot count still 19200.
- reset at plot 5000 -> next cycle: vga_plot=0, busy=0, rd_address=0, missed=0. A new start then sweeps from (0,0).
- Cell x=159, y=119 -> rd_address=15'h4FF7. RAM value 111 -> vga_colour=111.
- RD_LATENCY=2 -> first plot at E0+3; last plot at E0+19202; data aligned to coordinates throughout.
